// File: rtl/mem_port_arbiter_if.sv
// Requester-side bus shared by the CPU and I/O ports of mem_port_arbiter.
// master: the requester (CPU memory stage or I/O scanner).
// slave : the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-port synchronous RAM between the CPU
// memory stage and the I/O scanner. One access in flight at a time:
//   IDLE -> ISSUE -> IDLE            (write, 2 cycles)
//   IDLE -> ISSUE -> WAIT -> RESP    (read, 4 cycles)
// Default arbitration: fixed CPU priority, with the I/O port forced to win
// once it has lost STARVE_LIMIT consecutive arbitrations.
// Optional: define MEM_ARB_ROUND_ROBIN_EN for alternating priority on ties
// (starvation counter removed, STARVE_LIMIT ignored).
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clock,
  input  logic               reset,
  mem_port_arbiter_if.slave  cpu,
  mem_port_arbiter_if.slave  io,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_IO  = 1'b1
  } owner_t;

  state_t            state;
  state_t            state_next;
  owner_t            owner;
  logic              any_req;
  logic              pick_io;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] io_rdata_q;

  assign any_req = cpu.req | io.req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Set when the I/O port took the most recent grant; resets to I/O so the
  // CPU wins the first tie after reset.
  logic last_io;

  // Tie goes to whichever port was not granted last.
  always_comb begin
    pick_io = 1'b0;
    if (cpu.req && io.req) begin
      pick_io = ~last_io;
    end else begin
      pick_io = io.req;
    end
  end

  // Record which port won each IDLE arbitration.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_io <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_io <= pick_io;
    end
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  // I/O wins when starved, otherwise only when the CPU is not requesting.
  always_comb begin
    pick_io = 1'b0;
    if (io.req && (starve_cnt == LIMIT)) begin
      pick_io = 1'b1;
    end else if (cpu.req) begin
      pick_io = 1'b0;
    end else begin
      pick_io = io.req;
    end
  end

  // Count consecutive I/O losses; only IDLE edges are arbitration points.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!io.req || pick_io) begin
        starve_cnt <= '0;
      end else if (cpu.req && starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-port handshake pulses.
  always_comb begin
    state_next = state;
    cpu.gnt    = 1'b0;
    io.gnt     = 1'b0;
    cpu.rvalid = 1'b0;
    io.rvalid  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        cpu.gnt    = (owner == OWN_CPU);
        io.gnt     = (owner == OWN_IO);
        state_next = mem_we ? IDLE : WAIT;
      end
      WAIT: begin
        state_next = RESP;
      end
      RESP: begin
        cpu.rvalid = (owner == OWN_CPU);
        io.rvalid  = (owner == OWN_IO);
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // RAM command register, owner latch and per-port read data capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      owner       <= OWN_CPU;
      cpu_rdata_q <= '0;
      io_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= pick_io ? OWN_IO : OWN_CPU;
            mem_addr  <= pick_io ? io.addr  : cpu.addr;
            mem_we    <= pick_io ? io.we    : cpu.we;
            mem_wdata <= pick_io ? io.wdata : cpu.wdata;
          end
        end
        ISSUE: begin
          mem_we <= 1'b0;
        end
        WAIT: begin
          if (owner == OWN_CPU) begin
            cpu_rdata_q <= mem_rdata;
          end else begin
            io_rdata_q <= mem_rdata;
          end
        end
        default: begin
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  assign cpu.rdata = cpu_rdata_q;
  assign io.rdata  = io_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: per-cycle directed vector table plus a
// continuous-contention grant-order sequence. Honours MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  int unsigned applied    = 0;
  int unsigned miscompares = 0;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) cpu_if ();
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) io_if ();

  mem_port_arbiter #(
    .ADDR_W(16),
    .DATA_W(16),
    .STARVE_LIMIT(4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu       (cpu_if.slave),
    .io        (io_if.slave),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        creq, cwe;
    logic [15:0] caddr, cwd;
    logic        ireq, iwe;
    logic [15:0] iaddr, iwd;
    logic [15:0] mrd;
    logic        chk;
    logic        cg, cv;
    logic [15:0] crd;
    logic        ig, iv;
    logic [15:0] ird;
    logic [15:0] ma;
    logic        mwe;
    logic [15:0] mwd;
    logic        bsy;
  } vec_t;

  function automatic vec_t mk(
    input logic rst,
    input logic creq, input logic cwe, input logic [15:0] caddr, input logic [15:0] cwd,
    input logic ireq, input logic iwe, input logic [15:0] iaddr, input logic [15:0] iwd,
    input logic [15:0] mrd, input logic chk,
    input logic cg, input logic cv, input logic [15:0] crd,
    input logic ig, input logic iv, input logic [15:0] ird,
    input logic [15:0] ma, input logic mwe, input logic [15:0] mwd, input logic bsy);
    vec_t r;
    r.rst = rst; r.creq = creq; r.cwe = cwe; r.caddr = caddr; r.cwd = cwd;
    r.ireq = ireq; r.iwe = iwe; r.iaddr = iaddr; r.iwd = iwd; r.mrd = mrd; r.chk = chk;
    r.cg = cg; r.cv = cv; r.crd = crd; r.ig = ig; r.iv = iv; r.ird = ird;
    r.ma = ma; r.mwe = mwe; r.mwd = mwd; r.bsy = bsy;
    return r;
  endfunction

  vec_t vecs[29];
  logic [69:0] act, exp_v;

  // Expected grant order under continuous contention (1 = I/O).
  logic exp_io[10];
  int   got_cnt;

  task automatic drive(input vec_t v);
    reset         = v.rst;
    cpu_if.req    = v.creq;  cpu_if.we   = v.cwe;
    cpu_if.addr   = v.caddr; cpu_if.wdata = v.cwd;
    io_if.req     = v.ireq;  io_if.we    = v.iwe;
    io_if.addr    = v.iaddr; io_if.wdata = v.iwd;
    mem_rdata     = v.mrd;
  endtask

  initial begin
    // Each vector: inputs held for one cycle, outputs observed in that cycle.
    //            rst creq cwe caddr    cwd      ireq iwe iaddr    iwd      mrd      chk cg cv crd      ig iv ird      ma       mwe mwd      busy
    vecs[0]  = mk(1, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 0, 0,0,16'h0000, 0,0,16'h0000, 16'h0000,0,16'h0000,0);
    vecs[1]  = mk(1, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 1, 0,0,16'h0000, 0,0,16'h0000, 16'h0000,0,16'h0000,0);
    // CPU write 0x0010 <= 0xBEEF
    vecs[2]  = mk(0, 1,1,16'h0010,16'hBEEF, 0,0,16'h0000,16'h0000, 16'h0000, 1, 0,0,16'h0000, 0,0,16'h0000, 16'h0000,0,16'h0000,0);
    vecs[3]  = mk(0, 1,1,16'h0010,16'hBEEF, 0,0,16'h0000,16'h0000, 16'h0000, 1, 1,0,16'h0000, 0,0,16'h0000, 16'h0010,1,16'hBEEF,1);
    vecs[4]  = mk(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 1, 0,0,16'h0000, 0,0,16'h0000, 16'h0010,0,16'hBEEF,0);
    // CPU read 0x0010; I/O read 0x0200 arrives during the WAIT
    vecs[5]  = mk(0, 1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 1, 0,0,16'h0000, 0,0,16'h0000, 16'h0010,0,16'hBEEF,0);
    vecs[6]  = mk(0, 1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 1, 1,0,16'h0000, 0,0,16'h0000, 16'h0010,0,16'h0000,1);
    vecs[7]  = mk(0, 0,0,16'h0000,16'h0000, 1,0,16'h0200,16'h0000, 16'hBEEF, 1, 0,0,16'h0000, 0,0,16'h0000, 16'h0010,0,16'h0000,1);
    vecs[8]  = mk(0, 0,0,16'h0000,16'h0000, 1,0,16'h0200,16'h0000, 16'h0000, 1, 0,1,16'hBEEF, 0,0,16'h0000, 16'h0010,0,16'h0000,1);
    vecs[9]  = mk(0, 0,0,16'h0000,16'h0000, 1,0,16'h0200,16'h0000, 16'h0000, 1, 0,0,16'hBEEF, 0,0,16'h0000, 16'h0010,0,16'h0000,0);
    vecs[10] = mk(0, 0,0,16'h0000,16'h0000, 1,0,16'h0200,16'h0000, 16'h0000, 1, 0,0,16'hBEEF, 1,0,16'h0000, 16'h0200,0,16'h0000,1);
    vecs[11] = mk(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h1234, 1, 0,0,16'hBEEF, 0,0,16'h0000, 16'h0200,0,16'h0000,1);
    vecs[12] = mk(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 1, 0,0,16'hBEEF, 0,1,16'h1234, 16'h0200,0,16'h0000,1);
    // I/O read 0x0300, reset asserted during its WAIT
    vecs[13] = mk(0, 0,0,16'h0000,16'h0000, 1,0,16'h0300,16'h0000, 16'h0000, 1, 0,0,16'hBEEF, 0,0,16'h1234, 16'h0200,0,16'h0000,0);
    vecs[14] = mk(0, 0,0,16'h0000,16'h0000, 1,0,16'h0300,16'h0000, 16'h0000, 1, 0,0,16'hBEEF, 1,0,16'h1234, 16'h0300,0,16'h0000,1);
    vecs[15] = mk(1, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h5555, 1, 0,0,16'hBEEF, 0,0,16'h1234, 16'h0300,0,16'h0000,1);
    // After reset: simultaneous writes, CPU wins first
    vecs[16] = mk(0, 1,1,16'h0400,16'hAAAA, 1,1,16'h0500,16'hBBBB, 16'h0000, 1, 0,0,16'h0000, 0,0,16'h0000, 16'h0000,0,16'h0000,0);
    vecs[17] = mk(0, 1,1,16'h0400,16'hAAAA, 1,1,16'h0500,16'hBBBB, 16'h0000, 1, 1,0,16'h0000, 0,0,16'h0000, 16'h0400,1,16'hAAAA,1);
    vecs[18] = mk(0, 0,0,16'h0000,16'h0000, 1,1,16'h0500,16'hBBBB, 16'h0000, 1, 0,0,16'h0000, 0,0,16'h0000, 16'h0400,0,16'hAAAA,0);
    vecs[19] = mk(0, 0,0,16'h0000,16'h0000, 1,1,16'h0500,16'hBBBB, 16'h0000, 1, 0,0,16'h0000, 1,0,16'h0000, 16'h0500,1,16'hBBBB,1);
    // Back-to-back I/O writes 0x0100..0x0103
    vecs[20] = mk(0, 0,0,16'h0000,16'h0000, 1,1,16'h0100,16'hD000, 16'h0000, 1, 0,0,16'h0000, 0,0,16'h0000, 16'h0500,0,16'hBBBB,0);
    vecs[21] = mk(0, 0,0,16'h0000,16'h0000, 1,1,16'h0100,16'hD000, 16'h0000, 1, 0,0,16'h0000, 1,0,16'h0000, 16'h0100,1,16'hD000,1);
    vecs[22] = mk(0, 0,0,16'h0000,16'h0000, 1,1,16'h0101,16'hD001, 16'h0000, 1, 0,0,16'h0000, 0,0,16'h0000, 16'h0100,0,16'hD000,0);
    vecs[23] = mk(0, 0,0,16'h0000,16'h0000, 1,1,16'h0101,16'hD001, 16'h0000, 1, 0,0,16'h0000, 1,0,16'h0000, 16'h0101,1,16'hD001,1);
    vecs[24] = mk(0, 0,0,16'h0000,16'h0000, 1,1,16'h0102,16'hD002, 16'h0000, 1, 0,0,16'h0000, 0,0,16'h0000, 16'h0101,0,16'hD001,0);
    vecs[25] = mk(0, 0,0,16'h0000,16'h0000, 1,1,16'h0102,16'hD002, 16'h0000, 1, 0,0,16'h0000, 1,0,16'h0000, 16'h0102,1,16'hD002,1);
    vecs[26] = mk(0, 0,0,16'h0000,16'h0000, 1,1,16'h0103,16'hD003, 16'h0000, 1, 0,0,16'h0000, 0,0,16'h0000, 16'h0102,0,16'hD002,0);
    vecs[27] = mk(0, 0,0,16'h0000,16'h0000, 1,1,16'h0103,16'hD003, 16'h0000, 1, 0,0,16'h0000, 1,0,16'h0000, 16'h0103,1,16'hD003,1);
    vecs[28] = mk(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 1, 0,0,16'h0000, 0,0,16'h0000, 16'h0103,0,16'hD003,0);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 10; i++) exp_io[i] = (i % 2 == 1);
`else
    for (int i = 0; i < 10; i++) exp_io[i] = (i == 4) || (i == 9);
`endif

    drive(vecs[0]);

    // Directed per-cycle table
    for (int i = 0; i < 29; i++) begin
      @(negedge clock);
      drive(vecs[i]);
      #1;
      if (vecs[i].chk) begin
        act   = {cpu_if.gnt, cpu_if.rvalid, cpu_if.rdata, io_if.gnt, io_if.rvalid, io_if.rdata,
                 mem_addr, mem_we, mem_wdata, busy};
        exp_v = {vecs[i].cg, vecs[i].cv, vecs[i].crd, vecs[i].ig, vecs[i].iv, vecs[i].ird,
                 vecs[i].ma, vecs[i].mwe, vecs[i].mwd, vecs[i].bsy};
        applied++;
        if (act !== exp_v) begin
          miscompares++;
          $display("FAIL vec%0d: actual cg=%b cv=%b crd=%h ig=%b iv=%b ird=%h ma=%h we=%b wd=%h busy=%b required cg=%b cv=%b crd=%h ig=%b iv=%b ird=%h ma=%h we=%b wd=%h busy=%b",
                   i, act[69], act[68], act[67:52], act[51], act[50], act[49:34], act[33:18], act[17], act[16:1], act[0],
                   exp_v[69], exp_v[68], exp_v[67:52], exp_v[51], exp_v[50], exp_v[49:34], exp_v[33:18], exp_v[17], exp_v[16:1], exp_v[0]);
        end
      end
    end

    // Continuous contention: both ports hold write requests
    @(negedge clock);
    reset = 1'b1;
    cpu_if.req = 1'b0; io_if.req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    cpu_if.req = 1'b1; cpu_if.we = 1'b1; cpu_if.addr = 16'h0A00; cpu_if.wdata = 16'h1111;
    io_if.req  = 1'b1; io_if.we  = 1'b1; io_if.addr  = 16'h0B00; io_if.wdata  = 16'h2222;
    got_cnt = 0;
    for (int c = 0; c < 60 && got_cnt < 10; c++) begin
      #1;
      if (cpu_if.gnt && io_if.gnt) begin
        applied++;
        miscompares++;
        $display("FAIL dual_gnt: actual cpu_gnt=1 io_gnt=1 required at most one");
      end else if (cpu_if.gnt || io_if.gnt) begin
        applied++;
        if (io_if.gnt !== exp_io[got_cnt]) begin
          miscompares++;
          $display("FAIL grant%0d: actual io_won=%b required io_won=%b", got_cnt, io_if.gnt, exp_io[got_cnt]);
        end
        got_cnt++;
      end
      @(negedge clock);
    end
    if (got_cnt < 10) begin
      applied++;
      miscompares++;
      $display("FAIL grant_timeout: actual %0d grants required 10", got_cnt);
    end

    cpu_if.req = 1'b0;
    io_if.req  = 1'b0;
    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous program/data RAM between two requesters: the CPU core's memory stage and the I/O scanner, which writes module/switch state into RAM and reads display data.
- Fixed CPU priority, with starvation protection for the I/O port.
- Sequences each access (issue, read wait, response) and returns read data to the requester that issued it.

Parameters:
- ADDR_W, 16, address width of RAM and both ports
- DATA_W, 16, data width
- STARVE_LIMIT, 4, consecutive lost arbitrations after which the I/O port is forced to win; legal range 1..15

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held with cmd fields until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  one-cycle pulse: CPU command issued to RAM this cycle
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
- cpu_rdata  out  DATA_W  registered CPU read data
- io_req, io_we, io_addr, io_wdata, io_gnt, io_rvalid, io_rdata: same definitions as cpu_*, for the I/O port
- mem_addr  out  ADDR_W  registered RAM address
- mem_we  out  1  registered RAM write enable
- mem_wdata  out  DATA_W  registered RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after the read address is presented
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: state IDLE; all gnt/rvalid 0; mem_we 0; mem_addr, mem_wdata, cpu_rdata, io_rdata 0; starvation counter 0; owner CPU.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: a request in cycle T is sampled at the T edge.
  - Winner: io if io_req and counter == STARVE_LIMIT; else cpu if cpu_req; else io if io_req; else stay IDLE.
  - Winner's addr/we/wdata are registered into mem_*; owner is registered; next state ISSUE.
- ISSUE (cycle T+1):
  - mem_* hold the winner's command; the winner's gnt is high for exactly this cycle.
  - Write: next state IDLE, and mem_we returns to 0 in T+2.
  - Read: next state WAIT.
- WAIT (T+2): mem_rdata is valid; it is captured into the owner's rdata register at the T+2 edge; next state RESP.
- RESP (T+3): owner's rvalid = 1 and rdata is valid; next state IDLE. rdata holds its value until that port's next read completes.
- Latency, req sampled to gnt: 1 cycle. Read req to rvalid: 3 cycles. Writes occupy 2 cycles, reads 4. No pipelining; there is one outstanding access at most.
- Requesters must hold req and command stable until gnt. A requester may deassert req after gnt; a req still high in the cycle after gnt is a new request.
- Starvation counter, updated only on IDLE arbitration edges:
  - +1 when io_req = 1 and the CPU wins (saturates at STARVE_LIMIT).
  - Cleared to 0 when the I/O port wins, or when io_req = 0 at arbitration.
- Simultaneous cpu_req and io_req with counter < STARVE_LIMIT: the CPU wins.
- A request arriving during ISSUE/WAIT/RESP is not lost; it is arbitrated at the first IDLE edge.
- mem_we is never high outside ISSUE.
- Reset mid-operation: next edge gives IDLE with mem_we 0. Any pending rvalid is dropped and no gnt is issued. The counter clears; rdata registers clear.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - Fixed priority and the starvation counter are removed.
  - On simultaneous requests, the port not granted most recently wins; the last-granted flag resets to I/O, so the CPU wins the first tie after reset.
  - STARVE_LIMIT is ignored.
- Undefined: fixed CPU priority with the starvation counter, as above.

Test Plan:
- Reset, then CPU write addr 0x0010 data 0xBEEF: cpu_gnt at T+1 with mem_we = 1, mem_addr = 0x0010, mem_wdata = 0xBEEF; mem_we = 0 and busy = 0 at T+2.
- CPU read 0x0010, RAM model returns 0xBEEF: cpu_gnt at T+1, cpu_rvalid at T+3 with cpu_rdata = 0xBEEF; io_rvalid stays 0.
- cpu_req and io_req held continuously, STARVE_LIMIT = 4: grant order CPU, CPU, CPU, CPU, IO, CPU×4, IO. With MEM_ARB_ROUND_ROBIN_EN defined, grants alternate CPU, IO, CPU, IO.
- io_req asserted during the WAIT of a CPU read: io_gnt at the cycle after CPU RESP plus 1; no request dropped.
- reset asserted in the WAIT of an I/O read: no io_rvalid, mem_we = 0, state IDLE next cycle; the counter is 0, so a following simultaneous request grants CPU.
- Back-to-back I/O writes 0x0100..0x0103, no CPU traffic: io_gnt every 2 cycles; mem_wdata and mem_addr match each command in order.
